// File: rtl/ad9122_spi_wr_config.sv
// AD9122 power-up sequencer: pulses the DAC reset, then plays a fixed register
// table out as 16-bit 3-wire SPI frames, ending with a read-back of reg 0x08.
module ad9122_spi_wr_config #(
  parameter int CLK_DIV      = 4,
  parameter int RESET_CYCLES = 16,
  parameter int GAP_CYCLES   = 16
) (
  input  logic       clk_in,
  input  logic       rst_n,
  input  logic       datain_valid,
  output logic       datain_ready,
  output logic       o_sclk,
  output logic       o_sen_n,
  output logic       o_sda,
  output logic       o_sda_dir,
  input  logic       io_sda,
  output logic       o_reset,
  output logic [2:0] dbg_state,
  output logic [7:0] dbg_rd_data
);

  typedef enum logic [2:0] {
    RST_DAC  = 3'd0,
    IDLE     = 3'd1,
    LOAD     = 3'd2,
    CS_SETUP = 3'd3,
    SHIFT    = 3'd4,
    CS_HOLD  = 3'd5,
    GAP      = 3'd6
  } state_t;

  localparam int         NUM_ENTRIES = 8;
  localparam logic [2:0] LAST_IDX    = 3'(NUM_ENTRIES - 1);
  localparam logic [7:0] DIV_LAST    = 8'(CLK_DIV - 1);
  localparam logic [7:0] RST_LAST    = 8'(RESET_CYCLES - 1);
  // LOAD adds one cycle of o_sen_n high, so the gap counter stops one early.
  localparam logic [7:0] GAP_LAST    = 8'(GAP_CYCLES - 2);

  state_t      state;
  logic [7:0]  cnt;
  logic [2:0]  idx;
  logic [4:0]  nrise;
  logic [15:0] frame;
  logic [15:0] entry;
  logic [7:0]  rd_shift;
  logic [7:0]  rd_data;

  // Frame word: {R/W (1 = read), A6..A0, D7..D0}.
  function automatic logic [15:0] table_entry(input logic [2:0] i);
    case (i)
      3'd0:    return 16'h0000;
      3'd1:    return 16'h0110;
      3'd2:    return 16'h0300;
      3'd3:    return 16'h0400;
      3'd4:    return 16'h083F;
      3'd5:    return 16'h0ACF;
      3'd6:    return 16'h0CD1;
      default: return 16'h8800;
    endcase
  endfunction

  assign entry       = table_entry(idx);
  assign dbg_state   = state;
  assign dbg_rd_data = rd_data;

  // Start handshake: a transfer happens on a clk_in edge where datain_valid
  // and datain_ready are both high; ready is high only while in IDLE.
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      state        <= RST_DAC;
      cnt          <= 8'd0;
      idx          <= 3'd0;
      nrise        <= 5'd0;
      frame        <= 16'h0000;
      rd_shift     <= 8'h00;
      rd_data      <= 8'h00;
      o_sclk       <= 1'b0;
      o_sen_n      <= 1'b1;
      o_sda        <= 1'b0;
      o_sda_dir    <= 1'b0;
      o_reset      <= 1'b1;
      datain_ready <= 1'b0;
    end else begin
      case (state)
        RST_DAC: begin
          if (cnt == RST_LAST) begin
            cnt          <= 8'd0;
            o_reset      <= 1'b0;
            datain_ready <= 1'b1;
            state        <= IDLE;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        IDLE: begin
          if (datain_valid && datain_ready) begin
            idx          <= 3'd0;
            datain_ready <= 1'b0;
            state        <= LOAD;
          end
        end
        LOAD: begin
          frame   <= entry;
          o_sen_n <= 1'b0;
          o_sda   <= entry[15];
          cnt     <= 8'd0;
          state   <= CS_SETUP;
        end
        CS_SETUP: begin
          if (cnt == DIV_LAST) begin
            cnt    <= 8'd0;
            o_sclk <= 1'b1;
            nrise  <= 5'd1;
            state  <= SHIFT;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        SHIFT: begin
          if (cnt == DIV_LAST) begin
            cnt <= 8'd0;
            if (o_sclk) begin
              o_sclk <= 1'b0;
              if (nrise == 5'd16) begin
                if (frame[15]) rd_data <= rd_shift;
                state <= CS_HOLD;
              end else if (frame[15] && nrise >= 5'd8) begin
                // Read data phase: release SDIO after the instruction byte.
                o_sda_dir <= 1'b1;
                o_sda     <= 1'b0;
              end else begin
                o_sda <= frame[4'(5'd15 - nrise)];
              end
            end else begin
              o_sclk <= 1'b1;
              nrise  <= nrise + 5'd1;
              if (o_sda_dir) rd_shift <= {rd_shift[6:0], io_sda};
            end
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        CS_HOLD: begin
          if (cnt == DIV_LAST) begin
            cnt       <= 8'd0;
            o_sen_n   <= 1'b1;
            o_sda_dir <= 1'b0;
            o_sda     <= 1'b0;
            state     <= GAP;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        GAP: begin
          if (cnt == GAP_LAST) begin
            cnt <= 8'd0;
            if (idx == LAST_IDX) begin
              datain_ready <= 1'b1;
              state        <= IDLE;
            end else begin
              idx   <= idx + 3'd1;
              state <= LOAD;
            end
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        default: state <= RST_DAC;
      endcase
    end
  end

endmodule

// File: tb/tb_ad9122_spi_wr_config.sv
// Bench for ad9122_spi_wr_config: SPI frame monitor with an expected-frame
// queue, an SDIO device model for the read-back, and reset/abort scenarios.
module tb_ad9122_spi_wr_config;

  localparam int CLK_DIV      = 4;
  localparam int RESET_CYCLES = 16;
  localparam int GAP_CYCLES   = 16;

  logic       clk_in = 1'b0;
  logic       rst_n;
  logic       datain_valid;
  logic       datain_ready;
  logic       o_sclk, o_sen_n, o_sda, o_sda_dir, o_reset;
  logic       io_sda = 1'b0;
  logic [2:0] dbg_state;
  logic [7:0] dbg_rd_data;

  ad9122_spi_wr_config #(
    .CLK_DIV(CLK_DIV), .RESET_CYCLES(RESET_CYCLES), .GAP_CYCLES(GAP_CYCLES)
  ) dut (
    .clk_in(clk_in), .rst_n(rst_n), .datain_valid(datain_valid),
    .datain_ready(datain_ready), .o_sclk(o_sclk), .o_sen_n(o_sen_n),
    .o_sda(o_sda), .o_sda_dir(o_sda_dir), .io_sda(io_sda),
    .o_reset(o_reset), .dbg_state(dbg_state), .dbg_rd_data(dbg_rd_data)
  );

  // ---------------- clock ----------------
  always #10 clk_in = ~clk_in;

  // ---------------- scoreboard ----------------
  int n_cmp = 0;
  int n_err = 0;
  logic [15:0] exp_q[$];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=0x%0h expected=0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference register table, as listed for the DAC bring-up.
  logic       tbl_rd   [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
  logic [6:0] tbl_addr [8] = '{7'h00, 7'h01, 7'h03, 7'h04, 7'h08, 7'h0A, 7'h0C, 7'h08};
  logic [7:0] tbl_data [8] = '{8'h00, 8'h10, 8'h00, 8'h00, 8'h3F, 8'hCF, 8'hD1, 8'h00};

  int mon_frames = 0;

  task automatic load_expected(input logic [7:0] rd_val);
    exp_q.delete();
    for (int i = 0; i < 8; i++)
      exp_q.push_back({tbl_rd[i], tbl_addr[i], tbl_rd[i] ? rd_val : tbl_data[i]});
    mon_frames = 0;
  endtask

  // ---------------- SDIO device model ----------------
  logic [7:0] dev_val = 8'h3F;
  logic [7:0] dev_sh  = 8'h00;

  always @(negedge o_sclk) begin
    #1;
    if (o_sda_dir) begin
      io_sda = dev_sh[7];
      dev_sh = {dev_sh[6:0], 1'b0};
    end else begin
      io_sda = 1'b0;
      dev_sh = dev_val;
    end
  end

  // ---------------- SPI monitor (samples on falling clk_in) ----------------
  logic        in_frame = 1'b0;
  logic        prev_sen = 1'b1, prev_sclk = 1'b0, prev_sda = 1'b0, have_prev = 1'b0;
  logic [15:0] cur;
  int          mon_rises = 0, dir_bits = 0, hp_err = 0, stab_err = 0;
  int          ecnt = 0, hi_cnt = 0;

  always @(negedge clk_in) begin
    if (!rst_n) begin
      in_frame  = 1'b0;
      prev_sen  = 1'b1;
      prev_sclk = 1'b0;
      prev_sda  = 1'b0;
      have_prev = 1'b0;
      hi_cnt    = 0;
      ecnt      = 0;
    end else begin
      ecnt++;
      if (prev_sen && !o_sen_n) begin
        if (have_prev) check_eq("gap_ge_320ns", 32'(hi_cnt >= GAP_CYCLES), 1);
        in_frame  = 1'b1;
        cur       = 16'h0000;
        mon_rises = 0;
        dir_bits  = 0;
        hp_err    = 0;
        stab_err  = 0;
        ecnt      = 0;
      end else if (in_frame && o_sclk != prev_sclk) begin
        if (ecnt != CLK_DIV) hp_err++;
        ecnt = 0;
        if (o_sclk) begin
          mon_rises++;
          cur = {cur[14:0], o_sda_dir ? io_sda : o_sda};
          if (o_sda_dir) dir_bits++;
          if (o_sda != prev_sda) stab_err++;
        end
      end else if (in_frame && !prev_sen && o_sen_n) begin
        logic [15:0] e;
        if (ecnt != CLK_DIV) hp_err++;
        check_eq("frame_expected", 32'(exp_q.size() > 0), 1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          check_eq("frame_word", cur, e);
          check_eq("read_dir_bits", dir_bits, e[15] ? 8 : 0);
        end
        check_eq("rising_edges", mon_rises, 16);
        check_eq("sclk_half_period", hp_err, 0);
        check_eq("sda_stable", stab_err, 0);
        in_frame  = 1'b0;
        have_prev = 1'b1;
        mon_frames++;
      end
      if (o_sen_n) hi_cnt++;
      else hi_cnt = 0;
      prev_sen  = o_sen_n;
      prev_sclk = o_sclk;
      prev_sda  = o_sda;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wait_ready(input string tag);
    int c;
    for (c = 0; c < 200; c++) begin
      @(negedge clk_in);
      if (datain_ready) break;
    end
    check_eq(tag, 32'(c < 200), 1);
  endtask

  task automatic start_seq(input int hold_cycles);
    int lat;
    @(negedge clk_in);
    datain_valid = 1'b1;
    @(posedge clk_in);
    #1;
    check_eq("ready_drops_after_hs", datain_ready, 0);
    lat = 1;
    while (o_sen_n && lat < 10) begin
      @(posedge clk_in);
      #1;
      lat++;
    end
    check_eq("hs_to_sen_latency_le3", 32'(lat <= 3), 1);
    repeat (hold_cycles) @(negedge clk_in);
    datain_valid = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int c;
    for (c = 0; c < 6000; c++) begin
      @(negedge clk_in);
      if (datain_ready && exp_q.size() == 0 && !in_frame) break;
    end
    check_eq(tag, 32'(c < 6000), 1);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int c;
    rst_n        = 1'b0;
    datain_valid = 1'b0;

    #50;
    check_eq("rst_sen_n", o_sen_n, 1);
    check_eq("rst_sclk", o_sclk, 0);
    check_eq("rst_o_reset", o_reset, 1);
    check_eq("rst_ready", datain_ready, 0);
    check_eq("rst_sda_dir", o_sda_dir, 0);
    check_eq("rst_rd_data", dbg_rd_data, 8'h00);
    #150;

    @(negedge clk_in);
    rst_n = 1'b1;
    for (c = 1; c <= 100; c++) begin
      @(posedge clk_in);
      #1;
      if (!o_reset) break;
    end
    check_eq("o_reset_release_cycles", c, RESET_CYCLES);
    check_eq("ready_after_reset", datain_ready, 1);

    // Sequence 1: spec'd read-back value, valid held for 2 us.
    dev_val = 8'h3F;
    load_expected(dev_val);
    start_seq(100);
    wait_idle("seq1_idle");
    check_eq("seq1_frames", mon_frames, 8);
    check_eq("seq1_rd_data", dbg_rd_data, 8'h3F);

    // Sequence 2: random read value, extra valid pulse mid-sequence.
    dev_val = 8'($urandom_range(0, 255));
    load_expected(dev_val);
    start_seq(1);
    repeat ($urandom_range(200, 900)) @(negedge clk_in);
    datain_valid = 1'b1;
    #1;
    check_eq("ready_low_mid_seq", datain_ready, 0);
    repeat ($urandom_range(5, 40)) @(negedge clk_in);
    datain_valid = 1'b0;
    wait_idle("seq2_idle");
    check_eq("seq2_rd_data", dbg_rd_data, dev_val);
    repeat (300) @(negedge clk_in);
    check_eq("seq2_no_spurious_frames", mon_frames, 8);

    // Sequence 3: abort with rst_n during frame 3, bit 5.
    dev_val = 8'($urandom_range(0, 255));
    load_expected(dev_val);
    start_seq(1);
    for (c = 0; c < 3000; c++) begin
      @(posedge clk_in);
      if (mon_frames == 2 && in_frame && mon_rises == 5) break;
    end
    check_eq("abort_point_reached", 32'(c < 3000), 1);
    @(negedge clk_in);
    #3;
    rst_n = 1'b0;
    #1;
    check_eq("abort_sen_n", o_sen_n, 1);
    check_eq("abort_sda_dir", o_sda_dir, 0);
    check_eq("abort_sclk", o_sclk, 0);
    check_eq("abort_sda", o_sda, 0);
    check_eq("abort_o_reset", o_reset, 1);
    check_eq("abort_ready", datain_ready, 0);
    exp_q.delete();
    repeat (10) @(negedge clk_in);
    rst_n = 1'b1;
    wait_ready("abort_ready_again");
    check_eq("abort_o_reset_low", o_reset, 0);

    // Sequence 4: full replay from entry 0 after the abort.
    dev_val = 8'($urandom_range(0, 255));
    load_expected(dev_val);
    start_seq($urandom_range(1, 60));
    wait_idle("seq4_idle");
    check_eq("seq4_frames", mon_frames, 8);
    check_eq("seq4_rd_data", dbg_rd_data, dev_val);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
